// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register. Owns the PC, detects load-use hazards against
// the instruction in ID/EX, and handles branch/jump redirects resolved in ID.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [31:0]      imem_addr_o,
  input  logic [31:0]      imem_data_i,
  input  logic             branch_taken_i,
  input  logic [31:0]      branch_target_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      instruction_o,
  output logic             valid_o,
  output logic             bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [CNT_W-1:0] CntOne = 1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pc_id_q, pc_id_d;
  logic [31:0]      instr_q, instr_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [4:0]  id_rs, id_rt;
  logic        hazard;
  logic [31:0] pc_plus4;

  assign id_rs    = instr_q[25:21];
  assign id_rt    = instr_q[20:16];
  assign pc_plus4 = pc_q + 32'd4;

  // Load-use hazard; rs and rt are both checked regardless of format (conservative).
  always_comb begin
    hazard = valid_q & idex_memread_i & (idex_rt_i != 5'd0) &
             ((idex_rt_i == id_rs) | (idex_rt_i == id_rt));
  end

  // Next-state selection: hazard holds everything, then redirect, then sequential fetch.
  always_comb begin
    pc_d        = pc_q;
    pc_id_d     = pc_id_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hazard) begin
      // The stalled branch in ID has unresolved operands, so branch_taken_i is ignored.
      if (stall_cnt_q != CntMax) stall_cnt_d = stall_cnt_q + CntOne;
    end else if (branch_taken_i) begin
      pc_d    = {branch_target_i[31:2], 2'b00};
      pc_id_d = 32'd0;
      instr_d = 32'd0;
      valid_d = 1'b0;
      if (flush_cnt_q != CntMax) flush_cnt_d = flush_cnt_q + CntOne;
    end else begin
      pc_d    = pc_plus4;
      pc_id_d = pc_plus4;
      instr_d = imem_data_i;
      valid_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset overriding all other inputs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc_q        <= RESET_PC;
      pc_id_q     <= 32'd0;
      instr_q     <= 32'd0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      pc_id_q     <= pc_id_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_id_q;
  assign instruction_o = instr_q;
  assign valid_o       = valid_q;
  assign bubble_o      = hazard;
  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed vector table plus hand-written sequences.
module tb_if_id_stage;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        br;
  logic [31:0] tgt;
  logic        mr;
  logic [4:0]  rt;
  logic [31:0] pc_id;
  logic [31:0] instr;
  logic        valid;
  logic        bubble;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  logic        use_ovr;
  logic [31:0] ovr_word;

  // Second instance to exercise a reset PC near the top of the address space.
  logic        rst2;
  logic [31:0] imem_addr2, pc_id2, instr2;
  logic        valid2, bubble2;
  logic [15:0] stall_cnt2, flush_cnt2;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] AddInsn = 32'h00A6_1820;  // add $3,$5,$6: rs=5 rt=6

  assign imem_data = use_ovr ? ovr_word : (32'h2000_0000 | imem_addr);

  if_id_stage dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .imem_addr_o    (imem_addr),
    .imem_data_i    (imem_data),
    .branch_taken_i (br),
    .branch_target_i(tgt),
    .idex_memread_i (mr),
    .idex_rt_i      (rt),
    .pc_o           (pc_id),
    .instruction_o  (instr),
    .valid_o        (valid),
    .bubble_o       (bubble),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
  );

  if_id_stage #(
    .RESET_PC(32'hFFFF_FFF8),
    .CNT_W   (16)
  ) dut_wrap (
    .clk_i          (clk),
    .rst_i          (rst2),
    .imem_addr_o    (imem_addr2),
    .imem_data_i    (32'h0000_0000),
    .branch_taken_i (1'b0),
    .branch_target_i(32'h0000_0000),
    .idex_memread_i (1'b0),
    .idex_rt_i      (5'd0),
    .pc_o           (pc_id2),
    .instruction_o  (instr2),
    .valid_o        (valid2),
    .bubble_o       (bubble2),
    .stall_cnt_o    (stall_cnt2),
    .flush_cnt_o    (flush_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        br;
    logic [31:0] tgt;
    logic        mr;
    logic [4:0]  rt;
    logic        ovr;
    logic [31:0] word;
    logic        exp_bubble;
    logic [31:0] exp_addr;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    logic        exp_valid;
    logic [15:0] exp_stall;
    logic [15:0] exp_flush;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [31:0] a, input logic [31:0] i,
                             input logic [31:0] p, input logic v, input logic [15:0] s,
                             input logic [15:0] f);
    check({tag, " imem_addr"}, imem_addr, a);
    check({tag, " instruction"}, instr, i);
    check({tag, " pc_o"}, pc_id, p);
    check({tag, " valid"}, {31'd0, valid}, {31'd0, v});
    check({tag, " stall_cnt"}, {16'd0, stall_cnt}, {16'd0, s});
    check({tag, " flush_cnt"}, {16'd0, flush_cnt}, {16'd0, f});
  endtask

  initial begin
    //            br  tgt            mr  rt   ovr word     bub addr          instr          pc            v  st  fl
    vecs[0]  = '{1'b0, 32'h0,   1'b0, 5'd0, 1'b1, AddInsn, 1'b0, 32'h00C,  AddInsn,       32'h00C, 1'b1, 16'd0, 16'd0};
    vecs[1]  = '{1'b0, 32'h0,   1'b1, 5'd5, 1'b0, 32'h0,   1'b1, 32'h00C,  AddInsn,       32'h00C, 1'b1, 16'd1, 16'd0};
    vecs[2]  = '{1'b0, 32'h0,   1'b0, 5'd5, 1'b0, 32'h0,   1'b0, 32'h010,  32'h2000_000C, 32'h010, 1'b1, 16'd1, 16'd0};
    vecs[3]  = '{1'b0, 32'h0,   1'b1, 5'd0, 1'b0, 32'h0,   1'b0, 32'h014,  32'h2000_0010, 32'h014, 1'b1, 16'd1, 16'd0};
    vecs[4]  = '{1'b0, 32'h0,   1'b0, 5'd0, 1'b1, AddInsn, 1'b0, 32'h018,  AddInsn,       32'h018, 1'b1, 16'd1, 16'd0};
    vecs[5]  = '{1'b0, 32'h0,   1'b1, 5'd6, 1'b0, 32'h0,   1'b1, 32'h018,  AddInsn,       32'h018, 1'b1, 16'd2, 16'd0};
    vecs[6]  = '{1'b0, 32'h0,   1'b1, 5'd7, 1'b0, 32'h0,   1'b0, 32'h01C,  32'h2000_0018, 32'h01C, 1'b1, 16'd2, 16'd0};
    vecs[7]  = '{1'b1, 32'h103, 1'b0, 5'd0, 1'b0, 32'h0,   1'b0, 32'h100,  32'h0,         32'h0,   1'b0, 16'd2, 16'd1};
    vecs[8]  = '{1'b0, 32'h0,   1'b0, 5'd0, 1'b0, 32'h0,   1'b0, 32'h104,  32'h2000_0100, 32'h104, 1'b1, 16'd2, 16'd1};
    vecs[9]  = '{1'b0, 32'h0,   1'b0, 5'd0, 1'b1, AddInsn, 1'b0, 32'h108,  AddInsn,       32'h108, 1'b1, 16'd2, 16'd1};
    vecs[10] = '{1'b1, 32'h200, 1'b1, 5'd5, 1'b0, 32'h0,   1'b1, 32'h108,  AddInsn,       32'h108, 1'b1, 16'd3, 16'd1};
    vecs[11] = '{1'b1, 32'h200, 1'b0, 5'd5, 1'b0, 32'h0,   1'b0, 32'h200,  32'h0,         32'h0,   1'b0, 16'd3, 16'd2};
    vecs[12] = '{1'b1, 32'h306, 1'b1, 5'd5, 1'b0, 32'h0,   1'b0, 32'h304,  32'h0,         32'h0,   1'b0, 16'd3, 16'd3};
    vecs[13] = '{1'b0, 32'h0,   1'b0, 5'd0, 1'b0, 32'h0,   1'b0, 32'h308,  32'h2000_0304, 32'h308, 1'b1, 16'd3, 16'd3};

    rst = 1'b0; rst2 = 1'b0; br = 1'b0; tgt = '0; mr = 1'b0; rt = '0;
    use_ovr = 1'b0; ovr_word = '0;

    // Wrap-around instance: FFFF_FFF8 -> FFFF_FFFC -> 0000_0000.
    @(posedge clk); #1;
    check("wrap addr0", imem_addr2, 32'hFFFF_FFF8);
    rst2 = 1'b1;
    @(posedge clk); #1;
    check("wrap addr1", imem_addr2, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    check("wrap addr2", imem_addr2, 32'h0000_0000);

    // Reset state of the main instance.
    @(posedge clk); #1;
    check_state("reset", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0, 16'd0);
    check("reset bubble", {31'd0, bubble}, 32'd0);

    // Release and fetch the first two words.
    rst = 1'b1;
    @(posedge clk); #1;
    check_state("fetch0", 32'h4, 32'h2000_0000, 32'h4, 1'b1, 16'd0, 16'd0);
    @(posedge clk); #1;
    check_state("fetch1", 32'h8, 32'h2000_0004, 32'h8, 1'b1, 16'd0, 16'd0);

    for (int k = 0; k < 14; k++) begin
      br = vecs[k].br; tgt = vecs[k].tgt; mr = vecs[k].mr; rt = vecs[k].rt;
      use_ovr = vecs[k].ovr; ovr_word = vecs[k].word;
      #1;
      check($sformatf("vec%0d bubble", k), {31'd0, bubble}, {31'd0, vecs[k].exp_bubble});
      @(posedge clk); #1;
      check_state($sformatf("vec%0d", k), vecs[k].exp_addr, vecs[k].exp_instr,
                  vecs[k].exp_pc, vecs[k].exp_valid, vecs[k].exp_stall, vecs[k].exp_flush);
    end

    // Long stall: counter must saturate at all-ones and state must hold.
    br = 1'b0; mr = 1'b0; use_ovr = 1'b1; ovr_word = AddInsn;
    @(posedge clk); #1;
    use_ovr = 1'b0; mr = 1'b1; rt = 5'd5;
    repeat (70000) @(posedge clk);
    #1;
    check("sat bubble", {31'd0, bubble}, 32'd1);
    check_state("sat", 32'h30C, AddInsn, 32'h30C, 1'b1, 16'hFFFF, 16'd3);

    // Reset asserted mid-stall discards everything.
    rst = 1'b0;
    @(posedge clk); #1;
    check_state("rst_stall", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0, 16'd0);
    check("rst_stall bubble", {31'd0, bubble}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
